// File: rtl/basket_pkg.sv
// rtl/basket_pkg.sv - shared state encoding and field widths for the basketball timer
package basket_pkg;

   localparam int GAME_W = 10;
   localparam int SHOT_W = 5;
   localparam int PER_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_SHOT_VIOL,
      ST_PERIOD_END,
      ST_GAME_OVER
   } state_t;

endpackage

// File: rtl/basket_timer_ctrl_tick_gen.sv
// rtl/basket_timer_ctrl_tick_gen.sv - one-second tick divider that freezes its count while disabled
module tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic sclr,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == LAST);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_cnt <= '0;
      end else if (sclr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/basket_timer_ctrl.sv
// rtl/basket_timer_ctrl.sv - game clock, shot clock, period and horn controller
module basket_timer_ctrl
   import basket_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int GAME_SEC = 720,
   parameter int SHOT_SEC = 24,
   parameter int BUZZ_CYC = 25000000
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              pause,
   input  logic              shot_rst,
   input  logic              new_period,
   output logic [GAME_W-1:0] game_sec,
   output logic [SHOT_W-1:0] shot_sec,
   output logic [PER_W-1:0]  period,
   output logic              running,
   output logic              buzzer
);

   localparam int                BW       = $clog2(BUZZ_CYC + 1);
   localparam logic [GAME_W-1:0] GAME_RLD = GAME_W'(GAME_SEC);
   localparam logic [SHOT_W-1:0] SHOT_RLD = SHOT_W'(SHOT_SEC);
   localparam logic [BW-1:0]     BUZZ_RLD = BW'(BUZZ_CYC);

   state_t            r_state, w_state_n;
   logic [GAME_W-1:0] r_game, w_game_n, w_game_dec;
   logic [SHOT_W-1:0] r_shot, w_shot_n, w_shot_dec;
   logic [PER_W-1:0]  r_period, w_period_n;
   logic              r_running, r_buzzer;
   logic [BW-1:0]     r_buzz_cnt;
   logic              w_tick, w_sclr, w_buzz_trig;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .clr  (clr),
      .en   (r_state == ST_RUN),
      .sclr (w_sclr),
      .tick (w_tick)
   );

   assign w_game_dec = (r_game != '0) ? r_game - 1'b1 : '0;
   assign w_shot_dec = (r_shot != '0) ? r_shot - 1'b1 : '0;

   always_comb begin
      w_state_n   = r_state;
      w_game_n    = r_game;
      w_shot_n    = r_shot;
      w_period_n  = r_period;
      w_sclr      = 1'b0;
      w_buzz_trig = 1'b0;
      case (r_state)
         ST_IDLE, ST_PAUSE: begin
            if (shot_rst) w_shot_n = SHOT_RLD;
            if (!pause && start) w_state_n = ST_RUN;
         end
         ST_RUN: begin
            if (w_tick) begin
               w_game_n = w_game_dec;
               w_shot_n = shot_rst ? SHOT_RLD : w_shot_dec;
               // Game-clock expiry outranks a simultaneous shot-clock expiry
               if (w_game_dec == '0) begin
                  w_state_n   = ST_PERIOD_END;
                  w_buzz_trig = 1'b1;
               end else if (!shot_rst && w_shot_dec == '0) begin
                  w_state_n   = ST_SHOT_VIOL;
                  w_buzz_trig = 1'b1;
               end else if (pause) begin
                  w_state_n = ST_PAUSE;
               end
            end else begin
               if (shot_rst) w_shot_n = SHOT_RLD;
               if (pause) w_state_n = ST_PAUSE;
            end
         end
         ST_SHOT_VIOL: begin
            if (shot_rst) begin
               w_shot_n  = SHOT_RLD;
               w_state_n = ST_PAUSE;
            end
         end
         ST_PERIOD_END: begin
            if (new_period) begin
               if (r_period != PER_W'(3)) begin
                  w_period_n = r_period + 1'b1;
                  w_game_n   = GAME_RLD;
                  w_shot_n   = SHOT_RLD;
                  w_sclr     = 1'b1;
                  w_state_n  = ST_IDLE;
               end else begin
                  w_state_n = ST_GAME_OVER;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state    <= ST_IDLE;
         r_game     <= GAME_RLD;
         r_shot     <= SHOT_RLD;
         r_period   <= '0;
         r_running  <= 1'b0;
         r_buzz_cnt <= '0;
         r_buzzer   <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_game    <= w_game_n;
         r_shot    <= w_shot_n;
         r_period  <= w_period_n;
         r_running <= (w_state_n == ST_RUN);
         // Horn rises together with the new state; a retrigger restarts the count
         if (w_buzz_trig) begin
            r_buzz_cnt <= BUZZ_RLD;
            r_buzzer   <= 1'b1;
         end else if (r_buzz_cnt != '0) begin
            r_buzz_cnt <= r_buzz_cnt - 1'b1;
            r_buzzer   <= (r_buzz_cnt != BW'(1));
         end
      end
   end

   assign game_sec = r_game;
   assign shot_sec = r_shot;
   assign period   = r_period;
   assign running  = r_running;
   assign buzzer   = r_buzzer;

endmodule

// File: tb/tb_basket_timer_ctrl.sv
// tb/tb_basket_timer_ctrl.sv - directed self-checking bench for basket_timer_ctrl
module tb_basket_timer_ctrl;
   import basket_pkg::*;

   logic        clk, clr, start, pause, shot_rst, new_period;
   logic [9:0]  game_sec;
   logic [4:0]  shot_sec;
   logic [1:0]  period;
   logic        running, buzzer;
   int          n_pass, n_tot;

   basket_timer_ctrl #(.TICK_DIV(4), .GAME_SEC(10), .SHOT_SEC(4), .BUZZ_CYC(3)) dut (
      .clk(clk), .clr(clr), .start(start), .pause(pause), .shot_rst(shot_rst),
      .new_period(new_period), .game_sec(game_sec), .shot_sec(shot_sec),
      .period(period), .running(running), .buzzer(buzzer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      clr = 1'b0; start = 1'b0; pause = 1'b0; shot_rst = 1'b0; new_period = 1'b0;
      #12;
      n_tot++; if (game_sec !== 10'd10) $display("FAIL rst_game got %0d want 10", game_sec); else n_pass++;
      n_tot++; if (shot_sec !== 5'd4) $display("FAIL rst_shot got %0d want 4", shot_sec); else n_pass++;
      n_tot++; if (period !== 2'd0) $display("FAIL rst_period got %0d want 0", period); else n_pass++;
      n_tot++; if (running !== 1'b0 || buzzer !== 1'b0) $display("FAIL rst_run_buzz got %b%b want 00", running, buzzer); else n_pass++;
      clr = 1'b1;
      step(1);
      n_tot++; if (dut.r_state !== ST_IDLE || game_sec !== 10'd10) $display("FAIL rst_first_edge got st%0d g%0d want st0 g10", dut.r_state, game_sec); else n_pass++;
      new_period = 1'b1; step(1); new_period = 1'b0;
      n_tot++; if (period !== 2'd0 || dut.r_state !== ST_IDLE) $display("FAIL np_idle got p%0d st%0d want p0 st0", period, dut.r_state); else n_pass++;
   endtask

   task automatic test_shot_viol();
      int nb;
      start = 1'b1; step(1); start = 1'b0;
      n_tot++; if (running !== 1'b1) $display("FAIL sv_running got %b want 1", running); else n_pass++;
      step(15);
      n_tot++; if (shot_sec !== 5'd1 || game_sec !== 10'd7 || buzzer !== 1'b0) $display("FAIL sv_pre got s%0d g%0d b%b want s1 g7 b0", shot_sec, game_sec, buzzer); else n_pass++;
      step(1);
      n_tot++; if (shot_sec !== 5'd0 || game_sec !== 10'd6) $display("FAIL sv_vals got s%0d g%0d want s0 g6", shot_sec, game_sec); else n_pass++;
      n_tot++; if (dut.r_state !== ST_SHOT_VIOL || running !== 1'b0) $display("FAIL sv_state got st%0d r%b want st3 r0", dut.r_state, running); else n_pass++;
      nb = int'(buzzer);
      repeat (5) begin step(1); nb += int'(buzzer); end
      n_tot++; if (nb != 3) $display("FAIL sv_buzz_len got %0d want 3", nb); else n_pass++;
   endtask

   task automatic test_shot_viol_exit();
      start = 1'b1; step(1); start = 1'b0;
      n_tot++; if (dut.r_state !== ST_SHOT_VIOL || running !== 1'b0) $display("FAIL svx_start got st%0d r%b want st3 r0", dut.r_state, running); else n_pass++;
      shot_rst = 1'b1; step(1); shot_rst = 1'b0;
      n_tot++; if (shot_sec !== 5'd4 || dut.r_state !== ST_PAUSE || running !== 1'b0) $display("FAIL svx_rst got s%0d st%0d r%b want s4 st2 r0", shot_sec, dut.r_state, running); else n_pass++;
   endtask

   task automatic test_pause();
      start = 1'b1; step(1); start = 1'b0;
      step(1);
      pause = 1'b1; step(1); pause = 1'b0;
      n_tot++; if (running !== 1'b0) $display("FAIL pz_running got %b want 0", running); else n_pass++;
      step(20);
      n_tot++; if (game_sec !== 10'd6 || shot_sec !== 5'd4) $display("FAIL pz_frozen got g%0d s%0d want g6 s4", game_sec, shot_sec); else n_pass++;
      start = 1'b1; step(1); start = 1'b0;
      step(1);
      n_tot++; if (game_sec !== 10'd6 || running !== 1'b1) $display("FAIL pz_early got g%0d r%b want g6 r1", game_sec, running); else n_pass++;
      step(1);
      n_tot++; if (game_sec !== 10'd5 || shot_sec !== 5'd3) $display("FAIL pz_tick got g%0d s%0d want g5 s3", game_sec, shot_sec); else n_pass++;
   endtask

   task automatic test_shot_rst_tick();
      step(8);
      n_tot++; if (game_sec !== 10'd3 || shot_sec !== 5'd1) $display("FAIL srt_pre got g%0d s%0d want g3 s1", game_sec, shot_sec); else n_pass++;
      step(3);
      shot_rst = 1'b1; step(1); shot_rst = 1'b0;
      n_tot++; if (game_sec !== 10'd2 || shot_sec !== 5'd4) $display("FAIL srt_vals got g%0d s%0d want g2 s4", game_sec, shot_sec); else n_pass++;
      n_tot++; if (dut.r_state !== ST_RUN || buzzer !== 1'b0) $display("FAIL srt_state got st%0d b%b want st1 b0", dut.r_state, buzzer); else n_pass++;
   endtask

   task automatic test_periods();
      int nb;
      step(8);
      n_tot++; if (dut.r_state !== ST_PERIOD_END || game_sec !== 10'd0 || buzzer !== 1'b1) $display("FAIL pe0 got st%0d g%0d b%b want st4 g0 b1", dut.r_state, game_sec, buzzer); else n_pass++;
      start = 1'b1; step(1); start = 1'b0;
      n_tot++; if (dut.r_state !== ST_PERIOD_END || running !== 1'b0) $display("FAIL pe0_start got st%0d r%b want st4 r0", dut.r_state, running); else n_pass++;
      new_period = 1'b1; step(1); new_period = 1'b0;
      n_tot++; if (period !== 2'd1 || game_sec !== 10'd10 || shot_sec !== 5'd4 || dut.r_state !== ST_IDLE) $display("FAIL np1 got p%0d g%0d s%0d st%0d want p1 g10 s4 st0", period, game_sec, shot_sec, dut.r_state); else n_pass++;
      start = 1'b1; step(1); start = 1'b0;
      nb = 0;
      for (int t = 1; t <= 10; t++) begin
         for (int e = 0; e < 4; e++) begin
            shot_rst = ((t == 4 && e == 3) || (t == 7 && e == 0));
            step(1);
            if (!(t == 10 && e == 3)) nb += int'(buzzer);
         end
      end
      shot_rst = 1'b0;
      n_tot++; if (game_sec !== 10'd0 || shot_sec !== 5'd0) $display("FAIL pe1_vals got g%0d s%0d want g0 s0", game_sec, shot_sec); else n_pass++;
      n_tot++; if (dut.r_state !== ST_PERIOD_END || buzzer !== 1'b1 || nb != 0) $display("FAIL pe1_state got st%0d b%b early%0d want st4 b1 early0", dut.r_state, buzzer, nb); else n_pass++;
      new_period = 1'b1; step(1); new_period = 1'b0;
      n_tot++; if (period !== 2'd2) $display("FAIL np2 got %0d want 2", period); else n_pass++;
      for (int p = 2; p <= 3; p++) begin
         start = 1'b1; step(1); start = 1'b0;
         for (int t = 1; t <= 10; t++) begin
            for (int e = 0; e < 4; e++) begin
               shot_rst = (e == 3);
               step(1);
            end
         end
         shot_rst = 1'b0;
         n_tot++; if (dut.r_state !== ST_PERIOD_END || shot_sec !== 5'd4) $display("FAIL pe%0d got st%0d s%0d want st4 s4", p, dut.r_state, shot_sec); else n_pass++;
         new_period = 1'b1; step(1); new_period = 1'b0;
         if (p == 2) begin
            n_tot++; if (period !== 2'd3 || dut.r_state !== ST_IDLE) $display("FAIL np3 got p%0d st%0d want p3 st0", period, dut.r_state); else n_pass++;
         end else begin
            n_tot++; if (period !== 2'd3 || dut.r_state !== ST_GAME_OVER) $display("FAIL go_enter got p%0d st%0d want p3 st5", period, dut.r_state); else n_pass++;
         end
      end
      start = 1'b1; step(1); start = 1'b0;
      new_period = 1'b1; step(1); new_period = 1'b0;
      n_tot++; if (dut.r_state !== ST_GAME_OVER || running !== 1'b0 || period !== 2'd3 || game_sec !== 10'd0) $display("FAIL go_hold got st%0d r%b p%0d g%0d want st5 r0 p3 g0", dut.r_state, running, period, game_sec); else n_pass++;
   endtask

   task automatic test_clr_mid_run();
      clr = 1'b0; #2; clr = 1'b1;
      step(1);
      start = 1'b1; step(1); start = 1'b0;
      step(16);
      shot_rst = 1'b1; step(1); shot_rst = 1'b0;
      start = 1'b1; step(1); start = 1'b0;
      n_tot++; if (running !== 1'b1 || buzzer !== 1'b1 || game_sec !== 10'd6) $display("FAIL clr_pre got r%b b%b g%0d want r1 b1 g6", running, buzzer, game_sec); else n_pass++;
      #2; clr = 1'b0; #1;
      n_tot++; if (game_sec !== 10'd10 || shot_sec !== 5'd4 || period !== 2'd0) $display("FAIL clr_vals got g%0d s%0d p%0d want g10 s4 p0", game_sec, shot_sec, period); else n_pass++;
      n_tot++; if (running !== 1'b0 || buzzer !== 1'b0 || dut.r_state !== ST_IDLE) $display("FAIL clr_ctl got r%b b%b st%0d want r0 b0 st0", running, buzzer, dut.r_state); else n_pass++;
      #3; clr = 1'b1;
   endtask

   initial begin
      n_pass = 0; n_tot = 0;
      test_reset();
      test_shot_viol();
      test_shot_viol_exit();
      test_pause();
      test_shot_rst_tick();
      test_periods();
      test_clr_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
